// File: rtl/icache_pkg.sv
// Shared types and width helpers for the 2-way instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int tag_w(input int sets, input int words);
    return 32 - $clog2(sets) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bits (async reset), tag and data storage (not reset),
// a combinational lookup port and a single-word refill write port.
module icache_way
  import icache_pkg::*;
#(
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 8,
  localparam int INDEX_W = index_w(NUM_SETS),
  localparam int OFF_W   = off_w(WORDS_PER_LINE),
  localparam int TAG_W   = tag_w(NUM_SETS, WORDS_PER_LINE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [OFF_W-1:0]   rd_off,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_hit,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [OFF_W-1:0]   wr_off,
  input  logic [31:0]        wr_data,
  input  logic               tag_we,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               set_valid,
  input  logic               inval_all
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [31:0]         data_mem [NUM_SETS][WORDS_PER_LINE];

  always_comb begin
    rd_valid = valid_q[rd_index];
    rd_hit   = rd_valid && (tag_mem[rd_index] == rd_tag);
    rd_data  = data_mem[rd_index][rd_off];
  end

  // Invalidate-all wins over setting a line valid in the same cycle.
  always_comb begin
    valid_d = valid_q;
    if (inval_all)      valid_d = '0;
    else if (set_valid) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[wr_index][wr_off] <= wr_data;
    if (tag_we) tag_mem[wr_index]          <= wr_tag;
  end

endmodule

// File: rtl/icache_2way.sv
// 2-way set-associative I-cache with refill FSM, per-set LRU and flush.
// Define ICACHE_PERF_EN to add the HIT_CNT/MISS_CNT performance counters.
module icache_2way
  import icache_pkg::*;
#(
  parameter int          NUM_SETS       = 16,
  parameter int          WORDS_PER_LINE = 8,
  parameter logic [31:0] NOP_INSTR      = NOP_DEFAULT,
  localparam int INDEX_W = index_w(NUM_SETS),
  localparam int OFF_W   = off_w(WORDS_PER_LINE),
  localparam int TAG_W   = tag_w(NUM_SETS, WORDS_PER_LINE)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] PC,
  input  logic        PC_VALID,
  input  logic        FLUSH,
  output logic [31:0] INSTR,
  output logic        HIT,
  output logic        STALL,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] HIT_CNT,
  output logic [31:0] MISS_CNT
`endif
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  pc_index, idx_q, idx_d;
  logic [OFF_W-1:0]    pc_off, beat_q, beat_d;
  logic [TAG_W-1:0]    pc_tag, tag_q, tag_d;
  logic                victim_q, victim_d, fpend_q, fpend_d;
  logic [NUM_SETS-1:0] lru_q, lru_d;
  logic [31:0]         addr_q, addr_d;
  logic [1:0]          way_hit, way_valid;
  logic [1:0][31:0]    way_data;
  logic                any_hit, miss_start, beat_we, flush_eff, inval_all, pc_unused;

  assign pc_off    = PC[OFF_W+1:2];
  assign pc_index  = PC[OFF_W+INDEX_W+1:OFF_W+2];
  assign pc_tag    = PC[31:OFF_W+INDEX_W+2];
  assign pc_unused = ^PC[1:0];

  assign any_hit    = |way_hit;
  assign miss_start = (state_q == IDLE) && PC_VALID && !any_hit;
  assign beat_we    = (state_q == FILL) && MEM_RVALID;
  assign flush_eff  = fpend_q | FLUSH;
  assign inval_all  = ((state_q == IDLE) && FLUSH) || ((state_q == DONE) && flush_eff);

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way #(.NUM_SETS(NUM_SETS), .WORDS_PER_LINE(WORDS_PER_LINE)) u_way (
      .clk      (CLK),
      .rst_n    (RST_N),
      .rd_index (pc_index),
      .rd_off   (pc_off),
      .rd_tag   (pc_tag),
      .rd_valid (way_valid[w]),
      .rd_hit   (way_hit[w]),
      .rd_data  (way_data[w]),
      .wr_en    (beat_we && (victim_q == 1'(w))),
      .wr_index (idx_q),
      .wr_off   (beat_q),
      .wr_data  (MEM_RDATA),
      .tag_we   ((state_q == DONE) && (victim_q == 1'(w))),
      .wr_tag   (tag_q),
      .set_valid((state_q == DONE) && !flush_eff && (victim_q == 1'(w))),
      .inval_all(inval_all)
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_start) state_d = REQ;
      REQ:     if (MEM_ACK) state_d = FILL;
      FILL:    if (MEM_RVALID && beat_q == LAST_BEAT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    HIT      = PC_VALID && (state_q == IDLE) && any_hit;
    INSTR    = NOP_INSTR;
    if (HIT) INSTR = way_hit[0] ? way_data[0] : way_data[1];
    STALL    = (state_q != IDLE) || (PC_VALID && !HIT);
    MEM_REQ  = (state_q == REQ);
    MEM_ADDR = addr_q;
  end

  // LRU bit holds the victim way: a hit points it at the other way.
  always_comb begin
    idx_d    = idx_q;
    tag_d    = tag_q;
    victim_d = victim_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    fpend_d  = fpend_q;
    lru_d    = lru_q;
    if (HIT) lru_d[pc_index] = way_hit[0];
    if (miss_start) begin
      idx_d    = pc_index;
      tag_d    = pc_tag;
      addr_d   = {pc_tag, pc_index, {(OFF_W+2){1'b0}}};
      victim_d = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[pc_index]);
    end
    if (beat_we) beat_d = beat_q + 1'b1;
    if (state_q != IDLE && FLUSH) fpend_d = 1'b1;
    if (state_q == DONE) begin
      fpend_d       = 1'b0;
      lru_d[idx_q]  = ~victim_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q    <= '0;
      tag_q    <= '0;
      victim_q <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
      fpend_q  <= 1'b0;
      lru_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      fpend_q  <= fpend_d;
      lru_q    <= lru_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(HIT);
    miss_cnt_d = miss_cnt_q + 32'(miss_start);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_CNT  = hit_cnt_q;
  assign MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_2way.sv
// Bench for icache_2way: directed scenarios plus randomized traffic against a line-level model.
module tb_icache_2way;

  localparam int NS  = 16;
  localparam int WPL = 8;
  localparam int OW  = 3;
  localparam int IW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0, RST_N = 1'b0;
  logic [31:0] PC = '0, MEM_RDATA = '0;
  logic        PC_VALID = 1'b0, FLUSH = 1'b0, MEM_ACK = 1'b0, MEM_RVALID = 1'b0;
  logic [31:0] INSTR, MEM_ADDR;
  logic        HIT, STALL, MEM_REQ;
`ifdef ICACHE_PERF_EN
  logic [31:0] HIT_CNT, MISS_CNT;
`endif

  icache_2way dut (
    .CLK(CLK), .RST_N(RST_N), .PC(PC), .PC_VALID(PC_VALID), .FLUSH(FLUSH),
    .INSTR(INSTR), .HIT(HIT), .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
`ifdef ICACHE_PERF_EN
    , .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_total = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Line-level model: contents per way/set, victim pointer per set, and refill progress.
  bit          mv [2][NS];
  logic [31:0] mt [2][NS];
  logic [31:0] md [2][NS][WPL];
  bit          ml [NS];
  bit          busy, acked, fpend;
  int          beats, lset, lvic;
  logic [31:0] laddr, mhc, mmc;

  function automatic int f_set(input logic [31:0] a);
    return int'((a >> (2 + OW)) & (NS - 1));
  endfunction
  function automatic int f_word(input logic [31:0] a);
    return int'((a >> 2) & (WPL - 1));
  endfunction
  function automatic logic [31:0] f_tag(input logic [31:0] a);
    return a >> (2 + OW + IW);
  endfunction
  function automatic int m_way(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (mv[w][f_set(a)] && mt[w][f_set(a)] == f_tag(a)) return w;
    return -1;
  endfunction

  task automatic clear_valid();
    for (int w = 0; w < 2; w++) for (int s = 0; s < NS; s++) mv[w][s] = 1'b0;
  endtask

  task automatic model_reset();
    clear_valid();
    for (int s = 0; s < NS; s++) ml[s] = 1'b0;
    busy = 0; acked = 0; fpend = 0; beats = 0; laddr = '0; mhc = '0; mmc = '0;
  endtask

  task automatic check_cycle();
    int w;
    bit eh;
    logic [31:0] ei;
    w  = m_way(PC);
    eh = !busy && PC_VALID && (w >= 0);
    ei = NOP;
    if (eh) ei = md[w][f_set(PC)][f_word(PC)];
    chk("HIT", 32'(HIT), 32'(eh));
    chk("INSTR", INSTR, ei);
    chk("STALL", 32'(STALL), 32'(busy || (PC_VALID && !eh)));
    chk("MEM_REQ", 32'(MEM_REQ), 32'(busy && !acked));
    chk("MEM_ADDR", MEM_ADDR, laddr);
`ifdef ICACHE_PERF_EN
    chk("HIT_CNT", HIT_CNT, mhc);
    chk("MISS_CNT", MISS_CNT, mmc);
`endif
  endtask

  task automatic model_update();
    int s, w, v;
    bit h;
    s = f_set(PC);
    w = m_way(PC);
    if (!busy) begin
      h = PC_VALID && (w >= 0);
      v = !mv[0][s] ? 0 : (!mv[1][s] ? 1 : int'(ml[s]));
      if (h) begin ml[s] = (w == 0); mhc++; end
      if (FLUSH) clear_valid();
      if (PC_VALID && !h) begin
        busy = 1; acked = 0; beats = 0; lset = s; lvic = v;
        laddr = PC & ~32'(WPL * 4 - 1);
        mmc++;
      end
    end else if (!acked) begin
      if (MEM_ACK) acked = 1;
      if (FLUSH) fpend = 1;
    end else if (beats < WPL) begin
      if (MEM_RVALID) begin md[lvic][lset][beats] = MEM_RDATA; beats++; end
      if (FLUSH) fpend = 1;
    end else begin
      mt[lvic][lset] = f_tag(laddr);
      if (fpend || FLUSH) clear_valid();
      else mv[lvic][lset] = 1'b1;
      ml[lset] = (lvic == 0);
      fpend = 0;
      busy  = 0;
    end
  endtask

  // Inputs are driven at the falling edge; outputs checked 1 time unit later.
  task automatic tick();
    #1;
    if (!RST_N) model_reset();
    check_cycle();
    @(posedge CLK);
    if (RST_N) model_update();
    @(negedge CLK);
  endtask

  task automatic fill_beats(input logic [31:0] base, input int flush_at);
    for (int i = 0; i < WPL; i++) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = base + 32'(i);
      FLUSH      = (i == flush_at);
      tick();
    end
    MEM_RVALID = 1'b0;
    FLUSH      = 1'b0;
  endtask

  task automatic miss_fill(input logic [31:0] a, input logic [31:0] base,
                           input int flush_at, input logic exp_hit);
    PC = a; PC_VALID = 1'b1;
    tick();
    chk("mf_req", 32'(MEM_REQ), 32'd1);
    chk("mf_addr", MEM_ADDR, a & ~32'h1F);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    fill_beats(base, flush_at);
    tick();
    chk("mf_hit", 32'(HIT), 32'(exp_hit));
    if (exp_hit) chk("mf_instr", INSTR, base + 32'((a >> 2) & 7));
  endtask

  task automatic probe(input logic [31:0] a, input logic e);
    PC = a; PC_VALID = 1'b1;
    #1;
    chk($sformatf("probe_%h", a), 32'(HIT), 32'(e));
  endtask

  initial begin
    int got;
    model_reset();
    @(negedge CLK);
    tick(); tick();
    chk("rst_req", 32'(MEM_REQ), 32'd0);
    chk("rst_addr", MEM_ADDR, 32'd0);
    chk("rst_stall", 32'(STALL), 32'd0);
    RST_N = 1'b1;
    tick();

    // cold miss, then another word of the same line
    miss_fill(32'h100, 32'hA0, -1, 1'b1);
    chk("cold_stall", 32'(STALL), 32'd0);
    PC = 32'h11C;
    #1;
    chk("cold_word7", INSTR, 32'hA7);
    tick();

    // flush in IDLE: same-cycle hit, next cycle miss
    PC = 32'h100; FLUSH = 1'b1;
    #1;
    chk("flush_same_hit", 32'(HIT), 32'd1);
    tick();
    FLUSH = 1'b0;
    chk("flush_after_hit", 32'(HIT), 32'd0);
    chk("flush_after_stall", 32'(STALL), 32'd1);
    tick();
    chk("flush_req", 32'(MEM_REQ), 32'd1);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    fill_beats(32'hB0, -1);
    tick();
    chk("refill_instr", INSTR, 32'hB0);

    // two ways in set 8, LRU eviction
    miss_fill(32'h300, 32'hC0, -1, 1'b1);
    probe(32'h300, 1'b1); tick();
    probe(32'h100, 1'b1); tick();
    miss_fill(32'h500, 32'hD0, -1, 1'b1);
    probe(32'h100, 1'b1); tick();
    probe(32'h300, 1'b0);
    tick();
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    fill_beats(32'hE0, -1);
    tick();

    // flush mid-fill leaves everything invalid
    miss_fill(32'h700, 32'hF0, 3, 1'b0);
    probe(32'h100, 1'b0);
    probe(32'h300, 1'b0);
    PC = 32'h700;

    // delayed ack, stray beats, gapped refill, ignored PC changes
    tick();
    for (int i = 0; i < 5; i++) begin
      MEM_RVALID = (i % 2 == 1);
      MEM_RDATA  = $urandom;
      PC         = $urandom & ~32'h3;
      tick();
      chk("hs_addr", MEM_ADDR, 32'h700);
      chk("hs_req", 32'(MEM_REQ), 32'd1);
      chk("hs_stall", 32'(STALL), 32'd1);
    end
    MEM_ACK = 1'b1; MEM_RVALID = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    got = 0;
    for (int c = 0; c < 40 && got < WPL; c++) begin
      MEM_RVALID = (c % 3 != 0);
      MEM_RDATA  = MEM_RVALID ? 32'h1000 + 32'(got) : $urandom;
      if (MEM_RVALID) got++;
      tick();
      chk("gap_stall", 32'(STALL), 32'd1);
    end
    MEM_RVALID = 1'b0;
    PC = 32'h700;
    tick();
    for (int k = 0; k < WPL; k++) begin
      PC = 32'h700 + 32'(4 * k);
      #1;
      chk($sformatf("gap_word%0d", k), INSTR, 32'h1000 + 32'(k));
      tick();
    end

    // reset in the middle of a refill
    PC = 32'h900;
    tick();
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MEM_RVALID = 1'b1; MEM_RDATA = 32'h2000 + 32'(i); tick();
    end
    MEM_RVALID = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("midrst_req", 32'(MEM_REQ), 32'd0);
    chk("midrst_hit", 32'(HIT), 32'd0);
`ifdef ICACHE_PERF_EN
    chk("midrst_hcnt", HIT_CNT, 32'd0);
    chk("midrst_mcnt", MISS_CNT, 32'd0);
`endif
    tick();
    RST_N = 1'b1;
    probe(32'h900, 1'b0);
    probe(32'h700, 1'b0);
    tick();

    // randomized traffic over 4 tags x 4 sets
    for (int n = 0; n < 4000; n++) begin
      PC         = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
                 | (32'($urandom_range(0, 7)) << 2);
      PC_VALID   = ($urandom_range(0, 9) < 8);
      FLUSH      = ($urandom_range(0, 63) == 0);
      MEM_ACK    = ($urandom_range(0, 2) == 0);
      MEM_RVALID = ($urandom_range(0, 1) == 1);
      MEM_RDATA  = $urandom;
      RST_N      = ($urandom_range(0, 1999) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
